// File: rtl/max7219_cmd_seq.sv
// -----------------------------------------------------------------------------
// max7219_cmd_seq
//
// Frame sequencer that sits upstream of max7219_if. One accepted start request
// produces a complete refresh of a chain of G_NB_MATRIX cascaded MAX7219
// devices: five configuration registers (decode, intensity, scan limit,
// shutdown, display test) followed by the eight digit registers. Each register
// row is sent as one 16-bit frame per device, highest device first, and LOAD
// is enabled only on the final frame of a row so the whole chain latches once.
// Digit bytes are fetched from an external RAM with one cycle of read latency.
//
// Parameters
//   G_NB_MATRIX   number of cascaded MAX7219 devices (1..8)
//   G_ADDR_WIDTH  digit RAM address width, at least clog2(G_NB_MATRIX*8)
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   i_start        refresh request pulse, honoured only while idle
//   i_decode_mode  data for register 0x9, captured when a refresh is accepted
//   i_intensity    data[3:0] for register 0xA, captured on accept
//   i_scan_limit   data[2:0] for register 0xB, captured on accept
//   i_test_mode    data[0] for register 0xF, captured on accept
//   o_ram_addr     digit RAM address = device*8 + (digit-1)
//   i_ram_data     digit RAM read data, valid one cycle after o_ram_addr
//   o_start        one-cycle frame start pulse towards max7219_if
//   o_en_load      LOAD enable for the current frame, held until i_done
//   o_data         frame {4'h0, reg_addr, data}, held until i_done
//   i_done         one-cycle pulse from max7219_if: frame (and LOAD) complete
//   o_busy         high while a refresh is in progress
//   o_done         one-cycle pulse once the complete refresh has been sent
// -----------------------------------------------------------------------------
module max7219_cmd_seq #(
  parameter int G_NB_MATRIX  = 4,
  parameter int G_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [7:0]              i_decode_mode,
  input  logic [3:0]              i_intensity,
  input  logic [2:0]              i_scan_limit,
  input  logic                    i_test_mode,
  output logic [G_ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [7:0]              i_ram_data,
  output logic                    o_start,
  output logic                    o_en_load,
  output logic [15:0]             o_data,
  input  logic                    i_done,
  output logic                    o_busy,
  output logic                    o_done
);

  // Device counter reload value and the index of the last register row
  // (rows 0..4 are configuration, rows 5..12 are digits 1..8).
  localparam logic [2:0] DEV_LAST = 3'(G_NB_MATRIX - 1);
  localparam logic [3:0] REG_LAST = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [3:0] reg_idx_q;
  logic [2:0] dev_cnt_q;

  logic [7:0] decode_q;
  logic [3:0] intensity_q;
  logic [2:0] scan_limit_q;
  logic       test_mode_q;

  logic [3:0] row_addr;
  logic [7:0] row_data;
  logic [2:0] digit_sel;
  logic       last_dev;
  logic       last_reg;

  // Decode the current register row into its MAX7219 register address and
  // data byte. For digit rows the byte comes straight from the RAM read port,
  // which only holds the right byte during S_DATA; that is the only cycle in
  // which row_data is captured.
  always_comb begin
    row_addr  = 4'h0;
    row_data  = 8'h00;
    digit_sel = 3'd0;
    case (reg_idx_q)
      4'd0: begin
        row_addr = 4'h9;
        row_data = decode_q;
      end
      4'd1: begin
        row_addr = 4'hA;
        row_data = {4'h0, intensity_q};
      end
      4'd2: begin
        row_addr = 4'hB;
        row_data = {5'h00, scan_limit_q};
      end
      4'd3: begin
        row_addr = 4'hC;
        row_data = 8'h01;
      end
      4'd4: begin
        row_addr = 4'hF;
        row_data = {7'h00, test_mode_q};
      end
      default: begin
        row_addr  = reg_idx_q - 4'd4;
        row_data  = i_ram_data;
        digit_sel = 3'(reg_idx_q - 4'd5);
      end
    endcase
  end

  assign last_dev = (dev_cnt_q == 3'd0);
  assign last_reg = (reg_idx_q == REG_LAST);

  // The RAM address follows the counters directly, so it is already valid in
  // S_ADDR and the one-cycle RAM latency lands the byte in S_DATA. During
  // configuration rows it still points at digit 1 of the current device; the
  // byte read there is simply not used.
  assign o_ram_addr = G_ADDR_WIDTH'({dev_cnt_q, digit_sel});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded handshake outputs. i_start is only
  // looked at in S_IDLE and i_done only in S_WAIT, so stray pulses elsewhere
  // fall through without effect.
  always_comb begin
    state_d = state_q;
    o_start = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        o_busy  = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        o_busy  = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        o_busy  = 1'b1;
        o_start = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (i_done) begin
          if (last_dev && last_reg) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: configuration capture on accept, frame capture in S_DATA, and
  // row/device stepping on each completed frame. The devices are walked from
  // the far end of the chain down to device 0, whose frame carries LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_idx_q    <= 4'd0;
      dev_cnt_q    <= 3'd0;
      decode_q     <= 8'h00;
      intensity_q  <= 4'h0;
      scan_limit_q <= 3'd0;
      test_mode_q  <= 1'b0;
      o_data       <= 16'h0000;
      o_en_load    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            decode_q     <= i_decode_mode;
            intensity_q  <= i_intensity;
            scan_limit_q <= i_scan_limit;
            test_mode_q  <= i_test_mode;
            reg_idx_q    <= 4'd0;
            dev_cnt_q    <= DEV_LAST;
          end
        end
        S_DATA: begin
          o_data    <= {4'h0, row_addr, row_data};
          o_en_load <= last_dev;
        end
        S_WAIT: begin
          if (i_done) begin
            if (!last_dev) begin
              dev_cnt_q <= dev_cnt_q - 3'd1;
            end else if (!last_reg) begin
              reg_idx_q <= reg_idx_q + 4'd1;
              dev_cnt_q <= DEV_LAST;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_max7219_cmd_seq
//
// Directed bench for max7219_cmd_seq. Two instances are built, a single-device
// chain and a four-device chain, sharing configuration inputs and selected by
// 'sel'. A behavioural RAM holding 0x10+k at address k serves both, and the
// bench plays the max7219_if side of the start/done handshake.
// -----------------------------------------------------------------------------
module tb_max7219_cmd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic        sel;
  logic [7:0]  dec;
  logic [3:0]  inten;
  logic [2:0]  scan;
  logic        test;

  logic [4:0]  addr1, addr4;
  logic [7:0]  ram_q1, ram_q4;
  logic        start1, start4, en1, en4, busy1, busy4, fin1, fin4;
  logic [15:0] data1, data4;

  logic        m_start, m_en, m_busy, m_done;
  logic [15:0] m_data;

  logic [7:0]  mem [0:31];

  logic [7:0]  exp_dec;
  logic [3:0]  exp_int;
  logic [2:0]  exp_scan;
  logic        exp_test;

  int checks;
  int errors;

  max7219_cmd_seq #(.G_NB_MATRIX(1), .G_ADDR_WIDTH(5)) dut1 (
    .clk(clk), .rst(rst), .i_start(start & ~sel),
    .i_decode_mode(dec), .i_intensity(inten), .i_scan_limit(scan), .i_test_mode(test),
    .o_ram_addr(addr1), .i_ram_data(ram_q1),
    .o_start(start1), .o_en_load(en1), .o_data(data1), .i_done(done & ~sel),
    .o_busy(busy1), .o_done(fin1)
  );

  max7219_cmd_seq #(.G_NB_MATRIX(4), .G_ADDR_WIDTH(5)) dut4 (
    .clk(clk), .rst(rst), .i_start(start & sel),
    .i_decode_mode(dec), .i_intensity(inten), .i_scan_limit(scan), .i_test_mode(test),
    .o_ram_addr(addr4), .i_ram_data(ram_q4),
    .o_start(start4), .o_en_load(en4), .o_data(data4), .i_done(done & sel),
    .o_busy(busy4), .o_done(fin4)
  );

  assign m_start = sel ? start4 : start1;
  assign m_en    = sel ? en4    : en1;
  assign m_data  = sel ? data4  : data1;
  assign m_busy  = sel ? busy4  : busy1;
  assign m_done  = sel ? fin4   : fin1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model, one cycle of latency per instance.
  always @(posedge clk) begin
    ram_q1 <= mem[addr1];
    ram_q4 <= mem[addr4];
  end

  // Expected frame f of a refresh on an n-device chain: {en_load, frame}.
  function automatic logic [16:0] exp_frame(input int n, input int f);
    int row;
    int dev;
    logic [3:0] a;
    logic [7:0] d;
    row = f / n;
    dev = n - 1 - (f % n);
    case (row)
      0: begin a = 4'h9; d = exp_dec; end
      1: begin a = 4'hA; d = {4'h0, exp_int}; end
      2: begin a = 4'hB; d = {5'h00, exp_scan}; end
      3: begin a = 4'hC; d = 8'h01; end
      4: begin a = 4'hF; d = {7'h00, exp_test}; end
      default: begin a = 4'(row - 4); d = 8'(16 + dev * 8 + row - 5); end
    endcase
    return {(dev == 0), 4'h0, a, d};
  endfunction

  task automatic set_cfg(input logic [7:0] d, input logic [3:0] i, input logic [2:0] s, input logic t);
    dec = d; inten = i; scan = s; test = t;
    exp_dec = d; exp_int = i; exp_scan = s; exp_test = t;
  endtask

  // Runs one refresh whose i_start was raised by the caller at the current
  // negedge. dly < 0 cycles the done delay through 0/1/50. disturb pulses
  // i_start and changes intensity during frame 1. chain raises i_start in the
  // o_done cycle (must be ignored) and again one cycle later (accepted).
  task automatic do_refresh(input int n, input int dly, input bit disturb, input bit chain);
    int cnt;
    int d;
    logic [15:0] held_data;
    logic held_en;
    logic [16:0] ef;
    for (int f = 0; f < 13 * n; f++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
        cnt++;
      end while (m_start !== 1'b1 && cnt < 20);
      checks++;
      if (m_start !== 1'b1) begin
        errors++;
        $display("[TB] FAIL start_timeout frame %0d: o_start=%b, required 1 within 20 cycles", f, m_start);
        return;
      end
      checks++;
      if (cnt != 3) begin
        errors++;
        $display("[TB] FAIL start_latency frame %0d: got %0d cycles, required 3", f, cnt);
      end
      ef = exp_frame(n, f);
      checks++;
      if (m_data !== ef[15:0]) begin
        errors++;
        $display("[TB] FAIL frame_data n=%0d frame %0d: got %h, required %h", n, f, m_data, ef[15:0]);
      end
      checks++;
      if (m_en !== ef[16]) begin
        errors++;
        $display("[TB] FAIL frame_en_load n=%0d frame %0d: got %b, required %b", n, f, m_en, ef[16]);
      end
      held_data = m_data;
      held_en   = m_en;
      d = (dly >= 0) ? dly : ((f % 3 == 0) ? 0 : ((f % 3 == 1) ? 1 : 50));
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        if (disturb && f == 1 && k == 0) begin
          start = 1'b1;
          inten = 4'hF;
        end else begin
          start = 1'b0;
        end
        checks++;
        if (m_data !== held_data || m_en !== held_en || m_start !== 1'b0 || m_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL wait_hold frame %0d: data=%h en=%b start=%b busy=%b, required data=%h en=%b start=0 busy=1",
                   f, m_data, m_en, m_start, m_busy, held_data, held_en);
        end
      end
      done = 1'b1;
    end
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse: o_done=%b o_busy=%b, required o_done=1 o_busy=0", m_done, m_busy);
    end
    if (chain) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_after: o_done=%b o_busy=%b, required o_done=0 o_busy=0", m_done, m_busy);
    end
    if (chain) start = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({start1, en1, data1, busy1, fin1, addr1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_n1: start=%b en=%b data=%h busy=%b done=%b addr=%0d, required all 0",
               start1, en1, data1, busy1, fin1, addr1);
    end
    checks++;
    if ({start4, en4, data4, busy4, fin4, addr4} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_n4: start=%b en=%b data=%h busy=%b done=%b addr=%0d, required all 0",
               start4, en4, data4, busy4, fin4, addr4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_device();
    $display("[TB] single device refresh");
    sel = 1'b0;
    set_cfg(8'h00, 4'h7, 3'd7, 1'b0);
    start = 1'b1;
    do_refresh(1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_chain();
    $display("[TB] four device refresh");
    sel = 1'b1;
    set_cfg(8'hFF, 4'h3, 3'd5, 1'b1);
    start = 1'b1;
    do_refresh(4, 2, 1'b0, 1'b0);
  endtask

  task automatic test_latch();
    $display("[TB] mid-refresh start and intensity change");
    sel = 1'b1;
    set_cfg(8'h0F, 4'h7, 3'd3, 1'b0);
    start = 1'b1;
    do_refresh(4, 1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cnt;
    $display("[TB] reset during frame wait");
    sel = 1'b1;
    set_cfg(8'h00, 4'h5, 3'd7, 1'b0);
    start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end while (m_start !== 1'b1 && cnt < 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m_busy !== 1'b0 || m_start !== 1'b0 || m_data !== 16'h0000 || m_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: busy=%b start=%b data=%h en=%b, required all 0", m_busy, m_start, m_data, m_en);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (m_busy !== 1'b0 || m_start !== 1'b0 || m_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stale_done: busy=%b start=%b done=%b, required all 0", m_busy, m_start, m_done);
    end
    start = 1'b1;
    do_refresh(4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timing();
    $display("[TB] varied done delays");
    sel = 1'b0;
    set_cfg(8'hA5, 4'hC, 3'd2, 1'b1);
    start = 1'b1;
    do_refresh(1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    $display("[TB] start in done cycle then one cycle later");
    sel = 1'b0;
    set_cfg(8'h3C, 4'h1, 3'd4, 1'b0);
    start = 1'b1;
    do_refresh(1, 0, 1'b0, 1'b1);
    do_refresh(1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    done = 1'b0;
    sel = 1'b0;
    set_cfg(8'h00, 4'h0, 3'd0, 1'b0);
    for (int k = 0; k < 32; k++) mem[k] = 8'(8'h10 + k);
    test_reset();
    test_single_device();
    test_chain();
    test_latch();
    test_reset_mid();
    test_timing();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
